hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_src_match.sv | 42 ++++
 rtl/hazard_fwd_unit.sv | 81 ++++++++
 tb/tb_hazard_fwd_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and select encoding for the hazard/forwarding unit.
package hazard_pkg;

    // Widest register index an entry can hold; narrower indices are zero-extended.
    localparam int RD_MAX_W = 8;

    // Select value meaning "read the register file".
    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                is_load;
        logic [RD_MAX_W-1:0] rd;
    } hz_entry_t;

    function automatic int sel_width(input int fwd_stages);
        return $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one ID source operand against the in-flight entries.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SELW       = 2
) (
    input  logic [REG_AW-1:0]                rs,
    input  logic                             used,
    input  logic                             id_valid,
    input  hz_entry_t [FWD_STAGES-1:0]       ent,
    output logic [SELW-1:0]                  sel,
    output logic                             hazard
);

    logic hit;
    logic hit_load;
    int   hit_k;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (ent[k].valid && ent[k].regwrite && (ent[k].rd != '0) &&
                (ent[k].rd == RD_MAX_W'(rs)) && used && id_valid) begin
                hit      = 1'b1;
                hit_k    = k;
                hit_load = ent[k].is_load;
            end
        end
    end

    always_comb begin
        hazard = hit && hit_load && (hit_k < LOAD_STAGE);
        sel    = (hit && !hazard) ? SELW'(hit_k + 1) : SELW'(SEL_RF);
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// In-flight destination tracker producing forward selects, load-use stall and bubble.
// Optional stall counter ports/logic enabled by defining HAZARD_STALL_CNT_EN.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]                  id_rs,
    input  logic [NUM_SRC-1:0]                         id_rs_used,
    input  logic [REG_AW-1:0]                          id_rd,
    input  logic                                       id_regwrite,
    input  logic                                       id_is_load,
    input  logic                                       flush,
`ifdef HAZARD_STALL_CNT_EN
    input  logic                                       stall_cnt_clr,
    output logic [31:0]                                stall_cnt,
`endif
    output logic [NUM_SRC*sel_width(FWD_STAGES)-1:0]   fwd_sel,
    output logic                                       stall,
    output logic                                       bubble
);

    localparam int SELW = sel_width(FWD_STAGES);

    hz_entry_t [FWD_STAGES-1:0] ent_q;
    hz_entry_t [FWD_STAGES-1:0] ent_d;
    logic      [NUM_SRC-1:0]    src_hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_AW     (REG_AW),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_STAGE (LOAD_STAGE),
            .SELW       (SELW)
        ) u_match (
            .rs       (id_rs[i*REG_AW +: REG_AW]),
            .used     (id_rs_used[i]),
            .id_valid (id_valid),
            .ent      (ent_q),
            .sel      (fwd_sel[i*SELW +: SELW]),
            .hazard   (src_hazard[i])
        );
    end

    // Flush overrides a load-use hazard: the dependent instruction is gone anyway.
    assign stall  = (|src_hazard) && !flush;
    assign bubble = stall || flush;

    always_comb begin
        ent_d             = '0;
        ent_d[0].valid    = id_valid && !stall && !flush;
        ent_d[0].regwrite = id_regwrite;
        ent_d[0].is_load  = id_is_load;
        ent_d[0].rd       = RD_MAX_W'(id_rd);
        for (int k = 1; k < FWD_STAGES; k++) begin
            ent_d[k] = ent_q[k-1];
            // A flush also kills the instruction leaving EX.
            if (k == 1 && flush) ent_d[k].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ent_q <= '0;
        else        ent_q <= ent_d;
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stall_cnt <= '0;
        else if (stall_cnt_clr)              stall_cnt <= '0;
        else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed vector bench for hazard_fwd_unit (default parameters).
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        bubble;
`ifdef HAZARD_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .flush       (flush),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt),
`endif
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .bubble      (bubble)
    );

    typedef struct {
        logic       vld;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
        int         s0;
        int         s1;
        int         st;
        int         bb;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                                input logic [1:0] u, input logic [4:0] d, input logic w,
                                input logic l, input logic f, input int e0, input int e1,
                                input int est, input int ebb);
        vec_t t;
        t.vld = v; t.rs0 = r0; t.rs1 = r1; t.used = u; t.rd = d;
        t.rw = w; t.ld = l; t.fl = f; t.s0 = e0; t.s1 = e1; t.st = est; t.bb = ebb;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] u, input logic [4:0] d, input logic w,
                         input logic l, input logic f);
        id_valid = v; id_rs = {r1, r0}; id_rs_used = u; id_rd = d;
        id_regwrite = w; id_is_load = l; flush = f;
    endtask

    task automatic chk_out(input string tag, input int e0, input int e1, input int est, input int ebb);
        chk({tag, " sel0"},   int'(fwd_sel[1:0]), e0);
        chk({tag, " sel1"},   int'(fwd_sel[3:2]), e1);
        chk({tag, " stall"},  int'(stall), est);
        chk({tag, " bubble"}, int'(bubble), ebb);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            vld rs0 rs1 used   rd rw ld fl  s0 s1 st bb
        tv[0]  = mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        tv[1]  = mk(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        tv[2]  = mk(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        tv[3]  = mk(1'b1, 5'd9, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);
        tv[4]  = mk(1'b1, 5'd0, 5'd5, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0, 0, 2, 0, 0);
        tv[5]  = mk(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        tv[6]  = mk(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        tv[7]  = mk(1'b1, 5'd4, 5'd4, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        tv[8]  = mk(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        tv[9]  = mk(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0, 0, 0, 1, 1);
        tv[10] = mk(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0, 2, 0, 0, 0);
        tv[11] = mk(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0);
        tv[12] = mk(1'b1, 5'd0, 5'd9, 2'b10, 5'd9, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1);
        tv[13] = mk(1'b1, 5'd9, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif
        @(negedge clk);
        chk_out("in_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_out("post_release", 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].vld, tv[i].rs0, tv[i].rs1, tv[i].used, tv[i].rd, tv[i].rw, tv[i].ld, tv[i].fl);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tv[i].s0, tv[i].s1, tv[i].st, tv[i].bb);
            next_cycle();
        end

        // Reset with rd=3 in flight must leave nothing to forward from.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset sel0", int'(fwd_sel[1:0]), 1);
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 0, 0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("cnt in reset", int'(stall_cnt), 0);
`endif
        next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_out("after_reset", 0, 0, 0, 0);
        next_cycle();

`ifdef HAZARD_STALL_CNT_EN
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
            next_cycle();
            drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("cnt_hz%0d stall", n), int'(stall), 1);
            next_cycle();
            next_cycle();
        end
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_cnt", int'(stall_cnt), 3);
        stall_cnt_clr = 1'b1;
        next_cycle();
        stall_cnt_clr = 1'b0;
        @(negedge clk);
        chk("stall_cnt clr", int'(stall_cnt), 0);
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
